// File: rtl/snake_pkg.sv
// snake_pkg: shared grid geometry, master-state encodings and food placer state type
package snake_pkg;
  localparam int GRID_W = 160;
  localparam int GRID_H = 120;
  localparam int X_W = 8;
  localparam int Y_W = 7;
  typedef enum logic [1:0] {
    MS_START    = 2'b00,
    MS_PLAY     = 2'b01,
    MS_PAUSE    = 2'b10,
    MS_GAMEOVER = 2'b11
  } ms_t;
  typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_SCAN, S_DRAIN, S_ARMED} fp_state_t;
endpackage

// File: rtl/body_scanner.sv
// body_scanner: walks the snake body RAM and flags any segment equal to the candidate
//  clear          restart: address 0, latch SNAKE_LEN-1, drop hit and pending compare
//  issue          present body_addr to the RAM this cycle and advance
//  len            segment count sampled on clear
//  cand_x/cand_y  candidate food cell
//  body_x/body_y  RAM read data, one cycle after the address
//  body_addr      RAM read address
//  last           body_addr is the final segment
//  hit            a match was seen, including the data returning this cycle
module body_scanner import snake_pkg::*; #(
  parameter int LEN_W = 7
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             clear,
  input  logic             issue,
  input  logic [LEN_W-1:0] len,
  input  logic [X_W-1:0]   cand_x,
  input  logic [Y_W-1:0]   cand_y,
  input  logic [X_W-1:0]   body_x,
  input  logic [Y_W-1:0]   body_y,
  output logic [LEN_W-2:0] body_addr,
  output logic             last,
  output logic             hit
);
  localparam int A_W = LEN_W - 1;
  logic [A_W-1:0] last_idx;
  logic pend, hit_q;
  // The compare absorbs returning data even while paused, so a freeze never loses a match.
  assign hit  = hit_q | (pend && body_x == cand_x && body_y == cand_y);
  assign last = body_addr == last_idx;
  always_ff @(posedge CLK or posedge RESET)
    if (RESET) begin
      body_addr <= '0;
      last_idx  <= '0;
      pend      <= 1'b0;
      hit_q     <= 1'b0;
    end else if (clear) begin
      body_addr <= '0;
      last_idx  <= A_W'(len - 1'b1);
      pend      <= 1'b0;
      hit_q     <= 1'b0;
    end else begin
      pend  <= issue;
      hit_q <= hit;
      if (issue && !last) body_addr <= body_addr + 1'b1;
    end
endmodule

// File: rtl/food_placer.sv
// food_placer: places food off the snake body, detects eating and keeps the score
//  CLK, RESET          clock, asynchronous active-high reset
//  MASTER_STATE        game state: START / PLAY / PAUSE / GAMEOVER
//  TICK, HEAD_X/Y      game step strobe with the head position
//  SNAKE_LEN           live segments, sampled when a candidate arrives
//  RAND_X/Y, NEXT      random generator output and its request strobe
//  BODY_ADDR, BODY_X/Y body RAM read port (synchronous read)
//  FOOD_X/Y, FOOD_VALID accepted food cell
//  EAT, SCORE, FORCED  eat pulse, saturating score, sticky forced-accept flag
module food_placer import snake_pkg::*; #(
  parameter int MAX_LEN   = 64,
  parameter int MAX_RETRY = 15,
  parameter int SCORE_W   = 10,
  parameter int LEN_W     = $clog2(MAX_LEN + 1)
) (
  input  logic               CLK,
  input  logic               RESET,
  input  logic [1:0]         MASTER_STATE,
  input  logic               TICK,
  input  logic [X_W-1:0]     HEAD_X,
  input  logic [Y_W-1:0]     HEAD_Y,
  input  logic [LEN_W-1:0]   SNAKE_LEN,
  input  logic [X_W-1:0]     RAND_X,
  input  logic [Y_W-1:0]     RAND_Y,
  output logic               NEXT,
  output logic [LEN_W-2:0]   BODY_ADDR,
  input  logic [X_W-1:0]     BODY_X,
  input  logic [Y_W-1:0]     BODY_Y,
  output logic [X_W-1:0]     FOOD_X,
  output logic [Y_W-1:0]     FOOD_Y,
  output logic               FOOD_VALID,
  output logic               EAT,
  output logic [SCORE_W-1:0] SCORE,
  output logic               FORCED
);
  localparam int RC_W = $clog2(MAX_RETRY + 1);
  localparam logic [RC_W-1:0] RC_MAX = RC_W'(MAX_RETRY);
  fp_state_t state;
  logic [1:0] ms_q;
  logic [X_W-1:0] cand_x;
  logic [Y_W-1:0] cand_y;
  logic [RC_W-1:0] retry_cnt;
  logic start, pause, over, scan_clear, scan_issue, scan_last, scan_hit;
  assign start      = MASTER_STATE == MS_START;
  assign pause      = MASTER_STATE == MS_PAUSE;
  assign over       = MASTER_STATE == MS_GAMEOVER;
  assign scan_clear = state == S_IDLE || (state == S_WAIT && !pause);
  assign scan_issue = state == S_SCAN && !pause && !start;
  body_scanner #(.LEN_W(LEN_W)) u_scan (
    .CLK(CLK), .RESET(RESET), .clear(scan_clear), .issue(scan_issue), .len(SNAKE_LEN),
    .cand_x(cand_x), .cand_y(cand_y), .body_x(BODY_X), .body_y(BODY_Y),
    .body_addr(BODY_ADDR), .last(scan_last), .hit(scan_hit)
  );
  always_ff @(posedge CLK or posedge RESET)
    if (RESET) begin
      state      <= S_IDLE;
      ms_q       <= MS_START;
      cand_x     <= '0;
      cand_y     <= '0;
      retry_cnt  <= '0;
      NEXT       <= 1'b0;
      FOOD_X     <= '0;
      FOOD_Y     <= '0;
      FOOD_VALID <= 1'b0;
      EAT        <= 1'b0;
      SCORE      <= '0;
      FORCED     <= 1'b0;
    end else begin
      ms_q <= MASTER_STATE;
      NEXT <= 1'b0;
      EAT  <= 1'b0;
      if (start) begin
        state      <= S_IDLE;
        FOOD_VALID <= 1'b0;
        retry_cnt  <= '0;
      end else if (!pause) begin
        case (state)
          S_IDLE: begin
            FOOD_VALID <= 1'b0;
            retry_cnt  <= '0;
            if (MASTER_STATE == MS_PLAY) begin
              state <= S_REQ;
              NEXT  <= 1'b1;
              if (ms_q == MS_START) begin
                SCORE  <= '0;
                FORCED <= 1'b0;
              end
            end
          end
          // A pause landing on REQ swallows the strobe; re-issue it before moving on.
          S_REQ: if (NEXT) state <= S_WAIT; else NEXT <= 1'b1;
          S_WAIT: begin
            cand_x <= RAND_X;
            cand_y <= RAND_Y;
            state  <= SNAKE_LEN == '0 ? S_DRAIN : S_SCAN;
          end
          S_SCAN: if (scan_last) state <= S_DRAIN;
          S_DRAIN:
            if (scan_hit && retry_cnt < RC_MAX) begin
              retry_cnt <= retry_cnt + 1'b1;
              state     <= S_REQ;
              NEXT      <= 1'b1;
            end else begin
              FOOD_X     <= cand_x;
              FOOD_Y     <= cand_y;
              FOOD_VALID <= 1'b1;
              FORCED     <= FORCED | scan_hit;
              retry_cnt  <= '0;
              state      <= S_ARMED;
            end
          S_ARMED:
            if (TICK && !over && HEAD_X == FOOD_X && HEAD_Y == FOOD_Y) begin
              EAT        <= 1'b1;
              SCORE      <= SCORE == '1 ? SCORE : SCORE + 1'b1;
              FOOD_VALID <= 1'b0;
              state      <= S_REQ;
              NEXT       <= 1'b1;
            end
          default: state <= S_IDLE;
        endcase
      end
    end
endmodule

// File: tb/tb_food_placer.sv
// tb_food_placer: directed self-checking bench for food_placer
module tb_food_placer;
  import snake_pkg::*;
  logic CLK = 1'b0, RESET = 1'b1, TICK = 1'b0, NEXT, FOOD_VALID, EAT, FORCED;
  logic [1:0] MASTER_STATE = MS_START;
  logic [7:0] HEAD_X = '0, RAND_X, BODY_X, FOOD_X;
  logic [6:0] HEAD_Y = '0, RAND_Y, BODY_Y, FOOD_Y;
  logic [6:0] SNAKE_LEN = 7'd3;
  logic [5:0] BODY_ADDR;
  logic [9:0] SCORE;
  logic [7:0] ram_x [64];
  logic [6:0] ram_y [64];
  logic [14:0] gen_q [$];
  int next_cnt = 0, eat_cnt = 0, checks = 0, errors = 0, n, n0, e0;

  food_placer dut (
    .CLK(CLK), .RESET(RESET), .MASTER_STATE(MASTER_STATE), .TICK(TICK),
    .HEAD_X(HEAD_X), .HEAD_Y(HEAD_Y), .SNAKE_LEN(SNAKE_LEN), .RAND_X(RAND_X), .RAND_Y(RAND_Y),
    .NEXT(NEXT), .BODY_ADDR(BODY_ADDR), .BODY_X(BODY_X), .BODY_Y(BODY_Y),
    .FOOD_X(FOOD_X), .FOOD_Y(FOOD_Y), .FOOD_VALID(FOOD_VALID), .EAT(EAT),
    .SCORE(SCORE), .FORCED(FORCED)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) begin
    BODY_X <= ram_x[BODY_ADDR];
    BODY_Y <= ram_y[BODY_ADDR];
    if (EAT) eat_cnt <= eat_cnt + 1;
    if (NEXT) begin
      next_cnt <= next_cnt + 1;
      if (gen_q.size() > 0) {RAND_X, RAND_Y} <= gen_q.pop_front();
    end
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic wait_fv(input int bound, output int cnt);
    cnt = 0;
    do begin
      step();
      cnt++;
    end while (!FOOD_VALID && cnt < bound);
  endtask

  task automatic eat(input logic [7:0] x, input logic [6:0] y);
    HEAD_X = x;
    HEAD_Y = y;
    TICK = 1'b1;
    step();
    TICK = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 64; i++) begin
      ram_x[i] = 8'd150;
      ram_y[i] = 7'd110;
    end
    ram_x[0] = 8'd1; ram_y[0] = 7'd1;
    ram_x[1] = 8'd2; ram_y[1] = 7'd1;
    ram_x[2] = 8'd3; ram_y[2] = 7'd1;
    repeat (2) step();
    RESET = 1'b0;
    step();
    chk("rst_valid", FOOD_VALID, 0);
    chk("rst_next", NEXT, 0);
    chk("rst_score", SCORE, 0);
    chk("rst_addr", BODY_ADDR, 0);
    chk("rst_food_x", FOOD_X, 0);

    gen_q.push_back({8'd50, 7'd40});
    MASTER_STATE = MS_PLAY;
    wait_fv(30, n);
    chk("first_latency", n, 7);
    chk("first_nexts", next_cnt, 1);
    chk("first_food_x", FOOD_X, 50);
    chk("first_food_y", FOOD_Y, 40);
    chk("first_forced", FORCED, 0);

    n0 = next_cnt;
    HEAD_X = 8'd50; HEAD_Y = 7'd41; TICK = 1'b1;
    step();
    TICK = 1'b0;
    chk("miss_eat", EAT, 0);
    chk("miss_valid", FOOD_VALID, 1);
    chk("miss_next", NEXT, 0);

    gen_q.push_back({8'd2, 7'd1});
    gen_q.push_back({8'd90, 7'd10});
    eat(8'd50, 7'd40);
    chk("eat_pulse", EAT, 1);
    chk("eat_score", SCORE, 1);
    chk("eat_valid_drop", FOOD_VALID, 0);
    chk("eat_next", NEXT, 1);
    wait_fv(60, n);
    chk("retry_latency", n, 12);
    chk("retry_nexts", next_cnt - n0, 2);
    chk("retry_food_x", FOOD_X, 90);
    chk("retry_food_y", FOOD_Y, 10);
    chk("retry_forced", FORCED, 0);
    chk("eat_once", eat_cnt, 1);

    n0 = next_cnt;
    gen_q.push_back({8'd2, 7'd1});
    eat(8'd90, 7'd10);
    wait_fv(200, n);
    chk("forced_latency", n, 96);
    chk("forced_nexts", next_cnt - n0, 16);
    chk("forced_food_x", FOOD_X, 2);
    chk("forced_food_y", FOOD_Y, 1);
    chk("forced_flag", FORCED, 1);
    chk("forced_score", SCORE, 2);

    gen_q.push_back({8'd70, 7'd30});
    eat(8'd2, 7'd1);
    repeat (3) step();
    chk("pause_addr_pre", BODY_ADDR, 1);
    n0 = next_cnt;
    MASTER_STATE = MS_PAUSE;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("pause_addr", BODY_ADDR, 1);
      chk("pause_next", NEXT, 0);
    end
    MASTER_STATE = MS_PLAY;
    wait_fv(30, n);
    chk("resume_latency", n, 3);
    chk("resume_nexts", next_cnt - n0, 0);
    chk("resume_food_x", FOOD_X, 70);
    chk("resume_food_y", FOOD_Y, 30);
    chk("resume_score", SCORE, 3);

    e0 = eat_cnt;
    eat(8'd70, 7'd30);
    repeat (2) step();
    MASTER_STATE = MS_START;
    n0 = next_cnt;
    repeat (4) step();
    chk("abort_valid", FOOD_VALID, 0);
    chk("abort_nexts", next_cnt - n0, 0);
    chk("abort_score_held", SCORE, 4);
    gen_q.push_back({8'd80, 7'd20});
    MASTER_STATE = MS_PLAY;
    wait_fv(30, n);
    chk("replay_latency", n, 7);
    chk("replay_score_clr", SCORE, 0);
    chk("replay_forced_clr", FORCED, 0);
    chk("replay_food_x", FOOD_X, 80);

    eat(8'd80, 7'd20);
    chk("pre_rst_eat", EAT, 1);
    #2 RESET = 1'b1;
    #1;
    chk("async_rst_eat", EAT, 0);
    chk("async_rst_next", NEXT, 0);
    chk("async_rst_score", SCORE, 0);
    chk("async_rst_food_x", FOOD_X, 0);
    chk("async_rst_food_y", FOOD_Y, 0);
    chk("async_rst_valid", FOOD_VALID, 0);
    MASTER_STATE = MS_START;
    repeat (2) step();
    RESET = 1'b0;
    SNAKE_LEN = 7'd0;
    gen_q.push_back({8'd11, 7'd22});
    MASTER_STATE = MS_PLAY;
    wait_fv(30, n);
    chk("len0_latency", n, 4);
    chk("len0_food_x", FOOD_X, 11);
    chk("len0_food_y", FOOD_Y, 22);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
